// File: rtl/uvme_cvmcu_dbg_req_arb.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | uvme_cvmcu_dbg_req_arb: round-robin debug-request arbiter driving  |
// | the core halt/resume handshake, timer stop and halt-ack timeout.   |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module uvme_cvmcu_dbg_req_arb #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  input  logic                       halted_i,
  output logic                       debug_req_o,
  output logic                       stoptimer_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       timeout_o
);

  localparam int c_OWN_W = $clog2(NUM_REQ);
  localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;
  localparam logic [NUM_REQ-1:0] c_ONE      = NUM_REQ'(1);
  localparam logic [c_OWN_W-1:0] c_OWN_LAST = c_OWN_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_HALT   = 2'd2,
    S_RESUME = 2'd3
  } state_t;

  state_t               r_state, w_state_nx;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_nx;
  logic                 r_dbg, w_dbg_nx;
  logic                 r_stop, w_stop_nx;
  logic                 r_to, w_to_nx;
  logic [c_OWN_W-1:0]   r_owner, w_owner_nx;
  logic [c_OWN_W-1:0]   r_rr, w_rr_nx;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nx;

  logic [c_OWN_W-1:0]   w_pick;
  logic                 w_found;
  int                   w_idx;
  logic [c_OWN_W-1:0]   w_owner_inc;
  logic                 w_own_req;

  // First pending request at or after the round-robin pointer, wrapping.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_rr) + i;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (!w_found && req_i[c_OWN_W'(w_idx)]) begin
        w_found = 1'b1;
        w_pick  = c_OWN_W'(w_idx);
      end
    end
  end

  assign w_owner_inc = (r_owner == c_OWN_LAST) ? '0 : r_owner + c_OWN_W'(1);
  assign w_own_req   = req_i[r_owner];

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_dbg_nx   = r_dbg;
    w_stop_nx  = halted_i;
    w_to_nx    = 1'b0;
    w_owner_nx = r_owner;
    w_rr_nx    = r_rr;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_gnt_nx = '0;
        w_dbg_nx = 1'b0;
        // A core that entered debug by itself blocks arbitration.
        if (!halted_i && w_found) begin
          w_state_nx = S_ASSERT;
          w_owner_nx = w_pick;
          w_gnt_nx   = c_ONE << w_pick;
          w_dbg_nx   = 1'b1;
          w_cnt_nx   = '0;
        end
      end
      S_ASSERT: begin
        if (halted_i) begin
          w_state_nx = S_HALT;
          w_dbg_nx   = 1'b0;
        end else if (!w_own_req) begin
          w_state_nx = S_IDLE;
          w_gnt_nx   = '0;
          w_dbg_nx   = 1'b0;
          w_rr_nx    = w_owner_inc;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nx = S_IDLE;
          w_gnt_nx   = '0;
          w_dbg_nx   = 1'b0;
          w_to_nx    = 1'b1;
          w_rr_nx    = w_owner_inc;
        end else if (r_cnt != c_CNT_MAX) begin
          w_cnt_nx = r_cnt + c_CNT_W'(1);
        end
      end
      S_HALT: begin
        w_dbg_nx = 1'b0;
        if (!w_own_req) begin
          w_state_nx = S_RESUME;
          w_gnt_nx   = '0;
        end
      end
      S_RESUME: begin
        w_gnt_nx = '0;
        w_dbg_nx = 1'b0;
        if (!halted_i) begin
          w_state_nx = S_IDLE;
          w_rr_nx    = w_owner_inc;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = '0;
        w_dbg_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_dbg   <= 1'b0;
      r_stop  <= 1'b0;
      r_to    <= 1'b0;
      r_owner <= '0;
      r_rr    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_dbg   <= w_dbg_nx;
      r_stop  <= w_stop_nx;
      r_to    <= w_to_nx;
      r_owner <= w_owner_nx;
      r_rr    <= w_rr_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  assign gnt_o       = r_gnt;
  assign debug_req_o = r_dbg;
  assign stoptimer_o = r_stop;
  assign owner_o     = r_owner;
  assign timeout_o   = r_to;

endmodule
`default_nettype wire
